// File: rtl/ddr_burst_seq_if.sv
// rtl/ddr_burst_seq_if.sv - command, host FIFO and data-path signals of the burst sequencer
interface ddr_burst_seq_if;
    logic        CMD_WR;
    logic        CMD_RD;
    logic [1:0]  BL;
    logic [1:0]  SC_CL;
    logic        WR_DATA_REQ;
    logic [31:0] WDATA;
    logic [3:0]  WDM;
    logic        OE;
    logic [31:0] DATAIN;
    logic [3:0]  DM;
    logic [31:0] DATAOUT;
    logic [31:0] RDATA;
    logic        RD_VLD;
    logic        BUSY;
    logic        ERR;
    logic        ERR_CLR;

    modport slave (
        input  CMD_WR, CMD_RD, BL, SC_CL, WDATA, WDM, DATAOUT, ERR_CLR,
        output WR_DATA_REQ, OE, DATAIN, DM, RDATA, RD_VLD, BUSY, ERR
    );

    modport master (
        output CMD_WR, CMD_RD, BL, SC_CL, WDATA, WDM, DATAOUT, ERR_CLR,
        input  WR_DATA_REQ, OE, DATAIN, DM, RDATA, RD_VLD, BUSY, ERR
    );
endinterface

// File: rtl/ddr_burst_seq.sv
// rtl/ddr_burst_seq.sv - write/read burst sequencer between SDRAM command FSM and ddr_data_path
module ddr_burst_seq #(
    parameter int RD_BASE = 6,
    parameter int ERR_EN  = 1
) (
    input  logic             CLK100,
    input  logic             RESET_N,
    ddr_burst_seq_if.slave   bus
);
    localparam int DL_W = RD_BASE + 3;

    typedef enum logic {W_IDLE, W_RUN} wstate_t;

    wstate_t          wstate_q, wstate_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic [2:0]       rcnt_q, rcnt_d;
    logic             oe_q;
    logic [31:0]      datain_q;
    logic [3:0]       dm_q;
    logic [31:0]      rdata_q;
    logic             rd_vld_q;
    logic             err_q;
    logic [DL_W-1:0]  dl_q;

    logic       wr_req;
    logic [2:0] n_words;
    logic       bl_ok, wr_ok, rd_ok;
    logic       wr_viol, rd_viol, err_set;
    logic       issue;
    logic [DL_W:0] pipe;
    logic       pre_vld;
    logic       dl_any;

    always_comb begin
        case (bus.BL)
            2'b01:   n_words = 3'd1;
            2'b10:   n_words = 3'd2;
            2'b11:   n_words = 3'd4;
            default: n_words = 3'd0;
        endcase
    end

    assign bl_ok = (bus.BL != 2'b00);
    assign wr_ok = bus.CMD_WR & ~bus.CMD_RD & bl_ok;
    assign rd_ok = bus.CMD_RD & ~bus.CMD_WR & bl_ok;

    always_ff @(posedge CLK100 or negedge RESET_N) begin
        if (!RESET_N) begin
            wstate_q <= W_IDLE;
            wcnt_q   <= 3'd0;
        end else begin
            wstate_q <= wstate_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // A new write is only accepted on the final pop so back-to-back bursts stay gapless
    always_comb begin
        wstate_d = wstate_q;
        wcnt_d   = wcnt_q;
        wr_viol  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (wr_ok) begin
                    wstate_d = W_RUN;
                    wcnt_d   = n_words;
                end
            end
            W_RUN: begin
                if (wcnt_q == 3'd1) begin
                    if (wr_ok) begin
                        wcnt_d = n_words;
                    end else begin
                        wstate_d = W_IDLE;
                        wcnt_d   = 3'd0;
                    end
                end else begin
                    wcnt_d  = wcnt_q - 3'd1;
                    wr_viol = wr_ok;
                end
            end
            default: begin
                wstate_d = W_IDLE;
                wcnt_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        wr_req = (wstate_q == W_RUN);
    end

    always_comb begin
        rd_viol = 1'b0;
        if (rd_ok && (rcnt_q <= 3'd1)) begin
            rcnt_d = n_words;
        end else begin
            rcnt_d  = (rcnt_q != 3'd0) ? rcnt_q - 3'd1 : 3'd0;
            rd_viol = rd_ok;
        end
    end

    assign issue   = (rcnt_q != 3'd0);
    assign pipe    = {dl_q, issue};
    assign err_set = (bus.CMD_WR & bus.CMD_RD)
                   | ((bus.CMD_WR | bus.CMD_RD) & ~bl_ok)
                   | wr_viol | rd_viol;

    // Registering RD_VLD from the stage before the tap puts it exactly L cycles after issue
    always_comb begin
        pre_vld = 1'b0;
        dl_any  = 1'b0;
        for (int k = 0; k <= DL_W; k++) begin
            if (k == RD_BASE - 1 + int'(bus.SC_CL)) pre_vld = pipe[k];
        end
        for (int k = 0; k < DL_W; k++) begin
            if (k <= RD_BASE - 1 + int'(bus.SC_CL)) dl_any = dl_any | dl_q[k];
        end
    end

    always_ff @(posedge CLK100 or negedge RESET_N) begin
        if (!RESET_N) begin
            oe_q     <= 1'b0;
            datain_q <= 32'd0;
            dm_q     <= 4'd0;
            rcnt_q   <= 3'd0;
            dl_q     <= '0;
            rd_vld_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            oe_q <= wr_req;
            if (wr_req) begin
                datain_q <= bus.WDATA;
                dm_q     <= bus.WDM;
            end
            rcnt_q   <= rcnt_d;
            dl_q     <= {dl_q[DL_W-2:0], issue};
            rd_vld_q <= pre_vld;
            if (pre_vld) rdata_q <= bus.DATAOUT;
            if (err_set) err_q <= 1'b1;
            else if (bus.ERR_CLR) err_q <= 1'b0;
        end
    end

    assign bus.WR_DATA_REQ = wr_req;
    assign bus.OE          = oe_q;
    assign bus.DATAIN      = datain_q;
    assign bus.DM          = dm_q;
    assign bus.RDATA       = rdata_q;
    assign bus.RD_VLD      = rd_vld_q;
    assign bus.BUSY        = wr_req | oe_q | issue | dl_any;
    assign bus.ERR         = (ERR_EN != 0) && err_q;
endmodule

// File: tb/tb_ddr_burst_seq.sv
// tb/tb_ddr_burst_seq.sv - scoreboard bench for ddr_burst_seq
module tb_ddr_burst_seq;
    localparam int RD_BASE = 6;

    logic CLK100  = 1'b0;
    logic RESET_N = 1'b1;
    always #5 CLK100 = ~CLK100;

    ddr_burst_seq_if bus();

    ddr_burst_seq #(.RD_BASE(RD_BASE), .ERR_EN(1)) dut (
        .CLK100  (CLK100),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;
    int exp_req[$];
    int exp_oe[$];
    int exp_vld[$];
    int t;

    always @(posedge CLK100) cyc <= cyc + 1;

    function automatic logic [31:0] wdat(int c);
        return 32'hA500_0000 ^ 32'(c);
    endfunction
    function automatic logic [3:0] wdm(int c);
        return 4'(c);
    endfunction
    function automatic logic [31:0] dout(int c);
        return 32'h5D00_0000 ^ 32'(c * 7);
    endfunction

    // Host FIFO head and data-path read word change once per cycle, tagged by cycle number
    always @(posedge CLK100) begin
        #1;
        bus.WDATA   = wdat(cyc);
        bus.WDM     = wdm(cyc);
        bus.DATAOUT = dout(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge CLK100) begin
        if (bus.WR_DATA_REQ === 1'b1) begin
            if (exp_req.size() == 0) check("req_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            else check("req_cycle", 32'(cyc), 32'(exp_req.pop_front()));
        end
        if (bus.OE === 1'b1) begin
            if (exp_oe.size() == 0) check("oe_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            else begin
                check("oe_cycle", 32'(cyc), 32'(exp_oe.pop_front()));
                check("datain", bus.DATAIN, wdat(cyc - 1));
                check("dm", {28'd0, bus.DM}, {28'd0, wdm(cyc - 1)});
            end
        end
        if (bus.RD_VLD === 1'b1) begin
            if (exp_vld.size() == 0) check("vld_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            else begin
                check("vld_cycle", 32'(cyc), 32'(exp_vld.pop_front()));
                check("rdata", bus.RDATA, dout(cyc - 1));
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge CLK100);
            #1;
        end
    endtask

    // Drives a one-cycle command; accepted commands push their expected output cycles
    task automatic cmd(input logic wr, input logic rd, input logic [1:0] bl, input bit accept);
        int tc;
        int n;
        tc = cyc;
        n  = (bl == 2'd1) ? 1 : (bl == 2'd2) ? 2 : (bl == 2'd3) ? 4 : 0;
        bus.CMD_WR = wr;
        bus.CMD_RD = rd;
        bus.BL     = bl;
        if (accept) begin
            for (int k = 1; k <= n; k++) begin
                if (wr) begin
                    exp_req.push_back(tc + k);
                    exp_oe.push_back(tc + k + 1);
                end
                if (rd) exp_vld.push_back(tc + k + RD_BASE + int'(bus.SC_CL));
            end
        end
        idle(1);
        bus.CMD_WR = 1'b0;
        bus.CMD_RD = 1'b0;
    endtask

    task automatic err_clear();
        bus.ERR_CLR = 1'b1;
        idle(1);
        bus.ERR_CLR = 1'b0;
        check("err_cleared", 32'(bus.ERR), 32'd0);
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_req_left"}, 32'(exp_req.size()), 32'd0);
        check({tag, "_oe_left"},  32'(exp_oe.size()),  32'd0);
        check({tag, "_vld_left"}, 32'(exp_vld.size()), 32'd0);
    endtask

    task automatic flush();
        exp_req.delete();
        exp_oe.delete();
        exp_vld.delete();
    endtask

    initial begin
        bus.CMD_WR  = 1'b0;
        bus.CMD_RD  = 1'b0;
        bus.BL      = 2'b00;
        bus.SC_CL   = 2'd2;
        bus.ERR_CLR = 1'b0;
        bus.WDATA   = 32'd0;
        bus.WDM     = 4'd0;
        bus.DATAOUT = 32'd0;
        #2 RESET_N = 1'b0;
        idle(3);
        check("rst_req",    32'(bus.WR_DATA_REQ), 32'd0);
        check("rst_oe",     32'(bus.OE), 32'd0);
        check("rst_vld",    32'(bus.RD_VLD), 32'd0);
        check("rst_busy",   32'(bus.BUSY), 32'd0);
        check("rst_err",    32'(bus.ERR), 32'd0);
        check("rst_datain", bus.DATAIN, 32'd0);
        check("rst_rdata",  bus.RDATA, 32'd0);
        RESET_N = 1'b1;
        idle(3);

        t = cyc;
        cmd(1'b1, 1'b0, 2'b10, 1'b1);
        idle(5);
        check("wr2_err", 32'(bus.ERR), 32'd0);
        check("wr2_busy", 32'(bus.BUSY), 32'd0);
        check("wr2_datain_hold", bus.DATAIN, wdat(t + 2));
        drain_check("wr2");

        cmd(1'b1, 1'b0, 2'b11, 1'b1);
        idle(3);
        cmd(1'b1, 1'b0, 2'b11, 1'b1);
        idle(8);
        check("gapless_err", 32'(bus.ERR), 32'd0);
        drain_check("gapless");

        t = cyc;
        cmd(1'b0, 1'b1, 2'b11, 1'b1);
        idle(16);
        check("rd8_rdata_hold", bus.RDATA, dout(t + 11));
        check("rd8_busy", 32'(bus.BUSY), 32'd0);
        drain_check("rd8");

        for (int sc = 0; sc < 4; sc++) begin
            bus.SC_CL = 2'(sc);
            cmd(1'b0, 1'b1, 2'b01, 1'b1);
            idle(RD_BASE + sc);
            check("sweep_vld_last", 32'(bus.RD_VLD), 32'd1);
            check("sweep_busy_last", 32'(bus.BUSY), 32'd1);
            idle(1);
            check("sweep_busy_drop", 32'(bus.BUSY), 32'd0);
            idle(6);
        end
        bus.SC_CL = 2'd2;
        drain_check("sweep");

        cmd(1'b1, 1'b1, 2'b11, 1'b0);
        check("both_err", 32'(bus.ERR), 32'd1);
        err_clear();
        cmd(1'b0, 1'b1, 2'b11, 1'b1);
        cmd(1'b0, 1'b1, 2'b11, 1'b0);
        check("rd_overlap_err", 32'(bus.ERR), 32'd1);
        idle(14);
        err_clear();
        cmd(1'b1, 1'b0, 2'b00, 1'b0);
        check("bl0_err", 32'(bus.ERR), 32'd1);
        err_clear();
        cmd(1'b1, 1'b0, 2'b11, 1'b1);
        cmd(1'b1, 1'b0, 2'b11, 1'b0);
        check("wr_overlap_err", 32'(bus.ERR), 32'd1);
        idle(6);
        err_clear();
        bus.ERR_CLR = 1'b1;
        cmd(1'b0, 1'b1, 2'b00, 1'b0);
        bus.ERR_CLR = 1'b0;
        check("set_beats_clr", 32'(bus.ERR), 32'd1);
        err_clear();
        idle(4);
        drain_check("err");

        cmd(1'b1, 1'b0, 2'b11, 1'b1);
        idle(1);
        RESET_N = 1'b0;
        flush();
        #1;
        check("wrst_req",    32'(bus.WR_DATA_REQ), 32'd0);
        check("wrst_oe",     32'(bus.OE), 32'd0);
        check("wrst_datain", bus.DATAIN, 32'd0);
        check("wrst_busy",   32'(bus.BUSY), 32'd0);
        idle(2);
        RESET_N = 1'b1;
        idle(12);
        drain_check("wrst");

        cmd(1'b0, 1'b1, 2'b11, 1'b1);
        idle(4);
        RESET_N = 1'b0;
        flush();
        #1;
        check("rrst_vld",   32'(bus.RD_VLD), 32'd0);
        check("rrst_rdata", bus.RDATA, 32'd0);
        check("rrst_busy",  32'(bus.BUSY), 32'd0);
        idle(2);
        RESET_N = 1'b1;
        idle(16);
        check("rrst_busy_after", 32'(bus.BUSY), 32'd0);
        drain_check("rrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
